// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
//   DATA_W / ADDR_W : default write-data and register-index widths
//   wb_req_t        : a single writeback request (destination + data)
//   grant_e         : per-cycle arbitration outcome
package regfile_write_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    G_IDLE = 2'd0,
    G_PRI  = 2'd1,
    G_SEC  = 2'd2
  } grant_e;

endpackage

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// Circular-buffer FIFO for the secondary writeback source.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   push, push_addr/data    : enqueue (ignored when full)
//   pop                     : dequeue head (ignored when empty)
//   head_addr/head_data     : oldest entry
//   count                   : occupied entries
//   entry_addr/entry_valid  : flattened per-slot address and occupancy, for hazard lookup
// Handshake: push is honoured only when count < DEPTH; pop only when count > 0,
// evaluated on the pre-edge count, so an entry pushed into an empty FIFO cannot
// leave in the same cycle.
module regfile_write_arbiter_wb_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [ADDR_W-1:0]       push_addr,
  input  logic [DATA_W-1:0]       push_data,
  input  logic                    pop,
  output logic [ADDR_W-1:0]       head_addr,
  output logic [DATA_W-1:0]       head_data,
  output logic [CNT_W-1:0]        count,
  output logic [DEPTH*ADDR_W-1:0] entry_addr,
  output logic [DEPTH-1:0]        entry_valid
);

  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok, pop_ok;
  logic [PTR_W-1:0]  slot_off;

  always_comb begin
    push_ok  = push && (count_q != CNT_W'(DEPTH));
    pop_ok   = pop && (count_q != '0);
    // Pointers are PTR_W wide and DEPTH is a power of two, so they wrap naturally.
    rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push_ok) begin
        addr_mem_q[wr_ptr_q] <= push_addr;
        data_mem_q[wr_ptr_q] <= push_data;
      end
    end
  end

  // A slot is occupied when its distance from the read pointer is below count.
  always_comb begin
    slot_off    = '0;
    entry_addr  = '0;
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off                       = PTR_W'(i) - rd_ptr_q;
      entry_valid[i]                 = ({1'b0, slot_off} < count_q);
      entry_addr[i*ADDR_W +: ADDR_W] = addr_mem_q[i];
    end
  end

  assign head_addr = addr_mem_q[rd_ptr_q];
  assign head_data = data_mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between the in-order
// writeback stage (primary, priority) and long-latency units (secondary,
// buffered in a FIFO). A wait counter forces the FIFO to drain when its head
// has been passed over for STARVE_LIMIT cycles.
// Ports:
//   clk, rst                       : clock, asynchronous active-low reset
//   p_valid/p_ready/p_addr/p_data  : primary request; transfer when p_valid && p_ready
//   s_valid/s_ready/s_addr/s_data  : secondary request; transfer when s_valid && s_ready
//   rf_we/rf_waddr/rf_wdata        : registered register-file write port
//   chk_addr1/2, chk_hit1/2        : pending-write lookups for the hazard unit
//   fifo_count, starve_active      : FIFO occupancy and forced-drain state
// Valid/ready: a source may hold valid until ready; data is sampled at the
// posedge where valid && ready, and the result appears on rf_* one cycle later.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W       = regfile_write_arbiter_pkg::DATA_W,
  parameter int ADDR_W       = regfile_write_arbiter_pkg::ADDR_W,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8,
  localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1,
  localparam int WAIT_W      = $clog2(STARVE_LIMIT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_valid,
  output logic              p_ready,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              chk_hit1,
  output logic              chk_hit2,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              starve_active
);

  logic [CNT_W-1:0]             cnt;
  logic [ADDR_W-1:0]            head_addr;
  logic [DATA_W-1:0]            head_data;
  logic [FIFO_DEPTH*ADDR_W-1:0] entry_addr;
  logic [FIFO_DEPTH-1:0]        entry_valid;
  logic                         push, pop;
  logic [CNT_W-1:0]             cnt_next;
  grant_e                       grant;
  logic [ADDR_W-1:0]            sel_addr;
  logic [DATA_W-1:0]            sel_data;

  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              starve_q, starve_d;

  regfile_write_arbiter_wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .push        (push),
    .push_addr   (s_addr),
    .push_data   (s_data),
    .pop         (pop),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .count       (cnt),
    .entry_addr  (entry_addr),
    .entry_valid (entry_valid)
  );

  assign p_ready = !starve_q;
  assign s_ready = (cnt < CNT_W'(FIFO_DEPTH));
  assign push    = s_valid && s_ready;
  assign pop     = (grant == G_SEC);

  always_comb begin
    grant    = G_IDLE;
    sel_addr = p_addr;
    sel_data = p_data;
    if (p_valid && !starve_q) begin
      grant = G_PRI;
    end else if (cnt != '0) begin
      grant    = G_SEC;
      sel_addr = head_addr;
      sel_data = head_data;
    end
    // r0 writes are consumed but never reach the register file; address and
    // data hold their previous values whenever the write enable is low.
    rf_we_d    = (grant != G_IDLE) && (sel_addr != '0);
    rf_waddr_d = rf_we_d ? sel_addr : rf_waddr_q;
    rf_wdata_d = rf_we_d ? sel_data : rf_wdata_q;
  end

  always_comb begin
    cnt_next = cnt + CNT_W'(push) - CNT_W'(pop);
    if ((cnt == '0) || (grant == G_SEC)) begin
      wait_d = '0;
    end else if (wait_q != WAIT_W'(STARVE_LIMIT)) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = wait_q;
    end
    // Forced drain persists until the FIFO empties, even across new pushes.
    if (cnt_next == '0) begin
      starve_d = 1'b0;
    end else if (starve_q) begin
      starve_d = 1'b1;
    end else begin
      starve_d = (wait_d == WAIT_W'(STARVE_LIMIT));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      wait_q     <= '0;
      starve_q   <= 1'b0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      wait_q     <= wait_d;
      starve_q   <= starve_d;
    end
  end

  // A register is pending if it sits in the FIFO or in the output stage.
  always_comb begin
    chk_hit1 = 1'b0;
    chk_hit2 = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_valid[i] && (entry_addr[i*ADDR_W +: ADDR_W] == chk_addr1)) chk_hit1 = 1'b1;
      if (entry_valid[i] && (entry_addr[i*ADDR_W +: ADDR_W] == chk_addr2)) chk_hit2 = 1'b1;
    end
    if (rf_we_q && (rf_waddr_q == chk_addr1)) chk_hit1 = 1'b1;
    if (rf_we_q && (rf_waddr_q == chk_addr2)) chk_hit2 = 1'b1;
    if (chk_addr1 == '0) chk_hit1 = 1'b0;
    if (chk_addr2 == '0) chk_hit2 = 1'b0;
  end

  assign rf_we         = rf_we_q;
  assign rf_waddr      = rf_waddr_q;
  assign rf_wdata      = rf_wdata_q;
  assign fifo_count    = cnt;
  assign starve_active = starve_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_valid, p_ready;
  logic [4:0]  p_addr;
  logic [31:0] p_data;
  logic        s_valid, s_ready;
  logic [4:0]  s_addr;
  logic [31:0] s_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  chk_addr1, chk_addr2;
  logic        chk_hit1, chk_hit2;
  logic [2:0]  fifo_count;
  logic        starve_active;

  int tests = 0;
  int fails = 0;

  regfile_write_arbiter #(
    .DATA_W       (32),
    .ADDR_W       (5),
    .FIFO_DEPTH   (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .p_valid       (p_valid),
    .p_ready       (p_ready),
    .p_addr        (p_addr),
    .p_data        (p_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_addr        (s_addr),
    .s_data        (s_data),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .chk_addr1     (chk_addr1),
    .chk_addr2     (chk_addr2),
    .chk_hit1      (chk_hit1),
    .chk_hit2      (chk_hit2),
    .fifo_count    (fifo_count),
    .starve_active (starve_active)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // Driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int exp_cnt [9] = '{1, 2, 3, 4, 4, 4, 4, 4, 4};

  initial begin
    rst = 1'b0;
    p_valid = 1'b0; p_addr = '0; p_data = '0;
    s_valid = 1'b0; s_addr = '0; s_data = '0;
    chk_addr1 = '0; chk_addr2 = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_we",     32'(rf_we), 0);
    chk("rst_waddr",  32'(rf_waddr), 0);
    chk("rst_wdata",  rf_wdata, 0);
    chk("rst_count",  32'(fifo_count), 0);
    chk("rst_starve", 32'(starve_active), 0);
    rst = 1'b1;
    #1;
    chk("idle_p_ready", 32'(p_ready), 1);
    chk("idle_s_ready", 32'(s_ready), 1);

    // Primary only: one-cycle latency
    p_valid = 1'b1; p_addr = 5'd5; p_data = 32'hDEADBEEF;
    tick();
    chk("pri_we",    32'(rf_we), 1);
    chk("pri_waddr", 32'(rf_waddr), 5);
    chk("pri_wdata", rf_wdata, 32'hDEADBEEF);
    chk("pri_ready", 32'(p_ready), 1);
    p_valid = 1'b0;
    tick();
    chk("pri_idle_we",   32'(rf_we), 0);
    chk("pri_hold_addr", 32'(rf_waddr), 5);

    // Secondary only: two-cycle latency through the FIFO
    s_valid = 1'b1; s_addr = 5'd7; s_data = 32'h11; chk_addr1 = 5'd7;
    tick();
    s_valid = 1'b0;
    chk("sec_cnt1",   32'(fifo_count), 1);
    chk("sec_we_n1",  32'(rf_we), 0);
    chk("sec_hit_q",  32'(chk_hit1), 1);
    tick();
    chk("sec_we",    32'(rf_we), 1);
    chk("sec_waddr", 32'(rf_waddr), 7);
    chk("sec_wdata", rf_wdata, 32'h11);
    chk("sec_cnt0",  32'(fifo_count), 0);
    chk("sec_hit_o", 32'(chk_hit1), 1);
    tick();
    chk("sec_idle_we", 32'(rf_we), 0);
    chk("sec_hit_gone", 32'(chk_hit1), 0);

    // Fill with primary pressure, then starvation
    p_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      p_addr = 5'(20 + k); p_data = 32'(32'h2000 + k);
      if (k < 5) begin
        s_valid = 1'b1; s_addr = 5'(10 + k); s_data = 32'(32'h100 + k);
      end else begin
        s_valid = 1'b0;
      end
      #1;
      chk("fill_s_ready", 32'(s_ready), (k < 4) ? 1 : 0);
      tick();
      chk("fill_we",     32'(rf_we), 1);
      chk("fill_waddr",  32'(rf_waddr), 20 + k);
      chk("fill_wdata",  rf_wdata, 32'(32'h2000 + k));
      chk("fill_cnt",    32'(fifo_count), exp_cnt[k]);
      chk("fill_starve", 32'(starve_active), (k == 8) ? 1 : 0);
      chk("fill_p_rdy",  32'(p_ready), (k == 8) ? 0 : 1);
    end

    // Forced drain in FIFO order while primary is held off
    p_addr = 5'd30; p_data = 32'h5000;
    for (int j = 0; j < 4; j++) begin
      chk("drain_p_rdy", 32'(p_ready), 0);
      tick();
      chk("drain_we",     32'(rf_we), 1);
      chk("drain_waddr",  32'(rf_waddr), 10 + j);
      chk("drain_wdata",  rf_wdata, 32'(32'h100 + j));
      chk("drain_cnt",    32'(fifo_count), 3 - j);
      chk("drain_starve", 32'(starve_active), (j < 3) ? 1 : 0);
    end
    chk("post_p_rdy", 32'(p_ready), 1);
    tick();
    chk("post_pri_waddr", 32'(rf_waddr), 30);
    chk("post_pri_wdata", rf_wdata, 32'h5000);
    p_valid = 1'b0;
    tick();
    chk("post_idle_we", 32'(rf_we), 0);

    // r0 write and hazard lookups
    s_valid = 1'b1; s_addr = 5'd0; s_data = 32'hAA;
    chk_addr1 = 5'd9; chk_addr2 = 5'd0;
    tick();
    chk("r0_cnt",   32'(fifo_count), 1);
    chk("r0_hit2",  32'(chk_hit2), 0);
    chk("r0_hit1",  32'(chk_hit1), 0);
    s_addr = 5'd9; s_data = 32'h99;
    tick();
    chk("r0_we",      32'(rf_we), 0);
    chk("r0_hold",    32'(rf_waddr), 30);
    chk("r0_cnt_eq",  32'(fifo_count), 1);
    chk("r9_hit1_q",  32'(chk_hit1), 1);
    chk("r9_hit2",    32'(chk_hit2), 0);
    s_valid = 1'b0;
    tick();
    chk("r9_we",     32'(rf_we), 1);
    chk("r9_waddr",  32'(rf_waddr), 9);
    chk("r9_wdata",  rf_wdata, 32'h99);
    chk("r9_cnt",    32'(fifo_count), 0);
    chk("r9_hit1_o", 32'(chk_hit1), 1);
    tick();
    chk("r9_gone_we",  32'(rf_we), 0);
    chk("r9_gone_hit", 32'(chk_hit1), 0);

    // Reset mid-operation
    p_valid = 1'b1; s_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      p_addr = 5'(16 + k); p_data = 32'(32'h4000 + k);
      s_addr = 5'(1 + k);  s_data = 32'(k);
      tick();
    end
    chk("mid_cnt",   32'(fifo_count), 3);
    chk("mid_we",    32'(rf_we), 1);
    chk("mid_waddr", 32'(rf_waddr), 18);
    rst = 1'b0;
    #1;
    chk("arst_we",     32'(rf_we), 0);
    chk("arst_waddr",  32'(rf_waddr), 0);
    chk("arst_cnt",    32'(fifo_count), 0);
    chk("arst_starve", 32'(starve_active), 0);
    p_valid = 1'b0; s_valid = 1'b0;
    #2;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rel_we",  32'(rf_we), 0);
      chk("rel_cnt", 32'(fifo_count), 0);
    end
    p_valid = 1'b1; p_addr = 5'd3; p_data = 32'h33;
    tick();
    chk("new_we",    32'(rf_we), 1);
    chk("new_waddr", 32'(rf_waddr), 3);
    chk("new_wdata", rf_wdata, 32'h33);
    p_valid = 1'b0;
    tick();
    chk("new_idle", 32'(rf_we), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
